// File: rtl/p_mul_sched_if.sv
// Bundle of the two requester handshakes, their response handshakes and the
// shared packed-multiplier port. The scheduler uses the slave view; the
// requesters and the multiplier together form the master side.
interface p_mul_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [4:0]  req0_pw;
  logic [31:0] req0_crs1;
  logic [31:0] req0_crs2;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [4:0]  req1_pw;
  logic [31:0] req1_crs1;
  logic [31:0] req1_crs2;

  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp0_err;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;
  logic        rsp1_err;

  logic        mul_valid;
  logic        mul_ready;
  logic [2:0]  mul_op;
  logic [4:0]  mul_pw;
  logic [31:0] mul_crs1;
  logic [31:0] mul_crs2;
  logic [31:0] mul_result;

  modport slave (
    input  req0_valid, req0_op, req0_pw, req0_crs1, req0_crs2,
    input  req1_valid, req1_op, req1_pw, req1_crs1, req1_crs2,
    output req0_ready, req1_ready,
    input  rsp0_ready, rsp1_ready,
    output rsp0_valid, rsp0_result, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_err,
    output mul_valid, mul_op, mul_pw, mul_crs1, mul_crs2,
    input  mul_ready, mul_result
  );

  modport master (
    output req0_valid, req0_op, req0_pw, req0_crs1, req0_crs2,
    output req1_valid, req1_op, req1_pw, req1_crs1, req1_crs2,
    input  req0_ready, req1_ready,
    output rsp0_ready, rsp1_ready,
    input  rsp0_valid, rsp0_result, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_err,
    input  mul_valid, mul_op, mul_pw, mul_crs1, mul_crs2,
    output mul_ready, mul_result
  );
endinterface

// File: rtl/p_mul_sched.sv
// Two-requester round-robin scheduler in front of one shared packed /
// carry-less multiplier. Operands are latched at accept and held for the
// whole multiply; the result goes back on the owner's response handshake.
// Illegal pack widths and hung multiplies complete with err=1, result=0.
module p_mul_sched #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned TMR_W   = 6
) (
  input  logic         clock,
  input  logic         reset,
  p_mul_sched_if.slave bus,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic        rr_last_q, rr_last_d;
  logic        owner_q, owner_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  pw_q, pw_d;
  logic [31:0] crs1_q, crs1_d;
  logic [31:0] crs2_q, crs2_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic        mul_valid_q, mul_valid_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;

  logic        grant0, grant1;
  logic [2:0]  sel_op;
  logic [4:0]  sel_pw;
  logic [31:0] sel_crs1, sel_crs2;
  logic        sel_legal;
  logic        owner_ready;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      grant0 = bus.req0_valid & (~bus.req1_valid | rr_last_q);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~rr_last_q);
    end
  end

  assign sel_op      = grant1 ? bus.req1_op   : bus.req0_op;
  assign sel_pw      = grant1 ? bus.req1_pw   : bus.req0_pw;
  assign sel_crs1    = grant1 ? bus.req1_crs1 : bus.req0_crs1;
  assign sel_crs2    = grant1 ? bus.req1_crs2 : bus.req0_crs2;
  // Exactly one width bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_legal   = (sel_pw != 5'd0) && ((sel_pw & (sel_pw - 5'd1)) == 5'd0);
  assign owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  // Next-state and next-output logic for the IDLE -> BUSY -> RESP cycle.
  always_comb begin
    // NOTE: every _d starts from its held value so no path through the case leaves it unassigned (no inferred latches).
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    op_d        = op_q;
    pw_d        = pw_q;
    crs1_d      = crs1_q;
    crs2_d      = crs2_q;
    result_d    = result_q;
    err_d       = err_q;
    mul_valid_d = mul_valid_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          op_d    = sel_op;
          pw_d    = sel_pw;
          crs1_d  = sel_crs1;
          crs2_d  = sel_crs2;
          timer_d = '0;
          if (sel_legal) begin
            state_d     = BUSY;
            mul_valid_d = 1'b1;
          end else begin
            // Illegal width never reaches the multiplier.
            state_d     = RESP;
            err_d       = 1'b1;
            result_d    = '0;
            rsp_valid_d = {grant1, grant0};
          end
        end
      end
      BUSY: begin
        // A ready pulse in the timeout cycle still counts as success.
        if (bus.mul_ready) begin
          state_d     = RESP;
          mul_valid_d = 1'b0;
          result_d    = bus.mul_result;
          err_d       = 1'b0;
          rsp_valid_d = {owner_q, ~owner_q};
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d     = RESP;
          mul_valid_d = 1'b0;
          result_d    = '0;
          err_d       = 1'b1;
          rsp_valid_d = {owner_q, ~owner_q};
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESP: begin
        if (owner_ready) begin
          state_d     = IDLE;
          rr_last_d   = owner_q;
          rsp_valid_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clock) begin
    // NOTE: operand and result latches are reset too, because every mul_* and rsp_* output must read 0 after reset.
    if (reset) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      timer_q     <= '0;
      op_q        <= '0;
      pw_q        <= '0;
      crs1_q      <= '0;
      crs2_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      mul_valid_q <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      timer_q     <= timer_d;
      op_q        <= op_d;
      pw_q        <= pw_d;
      crs1_q      <= crs1_d;
      crs2_q      <= crs2_d;
      result_q    <= result_d;
      err_q       <= err_d;
      mul_valid_q <= mul_valid_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = rsp_valid_q[0] ? result_q : 32'd0;
  assign bus.rsp1_result = rsp_valid_q[1] ? result_q : 32'd0;
  assign bus.rsp0_err    = rsp_valid_q[0] & err_q;
  assign bus.rsp1_err    = rsp_valid_q[1] & err_q;
  assign bus.mul_valid   = mul_valid_q;
  assign bus.mul_op      = op_q;
  assign bus.mul_pw      = pw_q;
  assign bus.mul_crs1    = crs1_q;
  assign bus.mul_crs2    = crs2_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_p_mul_sched.sv
// Bench for p_mul_sched: a latency-programmable multiplier stub computes
// packed mul / clmul results from lane arithmetic; directed vectors, hand
// sequences and two random requester agents compare against that model.
`timescale 1ns/1ps
module tb_p_mul_sched;

  localparam int TIMEOUT = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;

  p_mul_sched_if bus ();

  p_mul_sched #(.TIMEOUT(TIMEOUT), .TMR_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Packed multiply reference: split into lanes of width w and use plain arithmetic per lane.
  function automatic logic [31:0] ref_mul(input logic [2:0] op, input logic [4:0] pw,
                                          input logic [31:0] a, input logic [31:0] b);
    int w;
    longint unsigned mask, x, y, p, r;
    w = pw[0] ? 32 : pw[1] ? 16 : pw[2] ? 8 : pw[3] ? 4 : 2;
    mask = (64'd1 << w) - 64'd1;
    r = 0;
    for (int l = 0; l < 32 / w; l++) begin
      x = (64'(a) >> (l * w)) & mask;
      y = (64'(b) >> (l * w)) & mask;
      if (op[2]) begin
        p = 0;
        for (int i = 0; i < w; i++) if (y[i]) p = p ^ (x << i);
      end else begin
        p = x * y;
        if (op[1]) p = p >> w;
      end
      r = r | ((p & mask) << (l * w));
    end
    return r[31:0];
  endfunction

  // Multiplier stub: ready pulses on the cur_lat-th cycle of mul_valid (0 = never).
  int stub_lat  = 1;
  bit stub_rand = 1'b0;
  int cur_lat   = 1;
  int mv_cnt    = 1;
  always @(posedge clock) begin
    if (!bus.mul_valid) begin
      mv_cnt  <= 1;
      cur_lat <= stub_rand ? int'($urandom_range(1, 33)) : stub_lat;
    end else begin
      mv_cnt <= mv_cnt + 1;
    end
  end
  assign bus.mul_ready  = bus.mul_valid && (cur_lat != 0) && (mv_cnt == cur_lat);
  assign bus.mul_result = bus.mul_ready ? ref_mul(bus.mul_op, bus.mul_pw, bus.mul_crs1, bus.mul_crs2)
                                        : 32'hDEAD_BEEF;

  // Round-robin monitor: under contention the grant goes to the requester not served last.
  int last_served = 1;
  always @(negedge clock) begin
    #2;
    if (reset) begin
      last_served = 1;
    end else begin
      if (bus.req0_valid && bus.req1_valid && (bus.req0_ready || bus.req1_ready))
        check("rr_grant", {bus.req0_ready, bus.req1_ready}, (last_served == 0) ? 2'b01 : 2'b10);
      if (bus.rsp0_valid && bus.rsp0_ready) last_served = 0;
      if (bus.rsp1_valid && bus.rsp1_ready) last_served = 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic drive_req(input int n, input logic v, input logic [2:0] op, input logic [4:0] pw,
                           input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_pw = pw; bus.req0_crs1 = a; bus.req0_crs2 = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_pw = pw; bus.req1_crs1 = a; bus.req1_crs2 = b;
    end
  endtask

  task automatic set_rsp_ready(input int n, input logic r);
    if (n == 0) bus.rsp0_ready = r;
    else        bus.rsp1_ready = r;
  endtask

  function automatic logic req_ready_of(input int n);
    return (n != 0) ? bus.req1_ready : bus.req0_ready;
  endfunction
  function automatic logic rsp_valid_of(input int n);
    return (n != 0) ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction
  function automatic logic [32:0] rsp_of(input int n);
    return (n != 0) ? {bus.rsp1_err, bus.rsp1_result} : {bus.rsp0_err, bus.rsp0_result};
  endfunction

  task automatic wait_rsp(input int n, input int limit, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clock);
      if (rsp_valid_of(n)) begin
        got = 1'b1;
        cyc = c;
        break;
      end
    end
  endtask

  task automatic ack_rsp(input int n);
    set_rsp_ready(n, 1'b1);
    @(posedge clock); #1;
    set_rsp_ready(n, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                           bus.rsp0_err, bus.rsp1_err, bus.mul_valid, busy}, 64'd0);
    check({tag, "_rsp_result"}, {bus.rsp0_result, bus.rsp1_result}, 64'd0);
    check({tag, "_mul_op_pw"}, {bus.mul_op, bus.mul_pw}, 64'd0);
    check({tag, "_mul_crs"}, {bus.mul_crs1, bus.mul_crs2}, 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          n;
    logic [2:0]  op;
    logic [4:0]  pw;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;          // multiplier cycles to ready, 0 = never
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_latency;  // accept to rsp_valid
    int          exp_mv;       // cycles mul_valid is high
  } vec_t;

  function automatic vec_t mk(input int n, input logic [2:0] op, input logic [4:0] pw,
                              input logic [31:0] a, input logic [31:0] b, input int lat,
                              input logic [31:0] res, input logic err, input int latency, input int mv);
    vec_t v;
    v.n = n; v.op = op; v.pw = pw; v.a = a; v.b = b; v.lat = lat;
    v.exp_res = res; v.exp_err = err; v.exp_latency = latency; v.exp_mv = mv;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int  mv;
    int  cyc;
    bit  got;
    bit  stable;
    stub_lat = v.lat;
    @(negedge clock);
    drive_req(v.n, 1'b1, v.op, v.pw, v.a, v.b);
    #1;
    check({tag, "_accept"}, req_ready_of(v.n), 1'b1);
    @(posedge clock); #1;
    drive_req(v.n, 1'b0, v.op, v.pw, v.a, v.b);
    mv = 0; cyc = 0; got = 1'b0; stable = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (bus.mul_valid) begin
        mv++;
        if ({bus.mul_op, bus.mul_pw, bus.mul_crs1, bus.mul_crs2} !== {v.op, v.pw, v.a, v.b}) stable = 1'b0;
      end
      if (rsp_valid_of(v.n)) begin
        got = 1'b1;
        cyc = c;
        break;
      end
    end
    check({tag, "_latency"}, cyc, v.exp_latency);
    check({tag, "_mul_valid_cycles"}, mv, v.exp_mv);
    check({tag, "_mul_operands_stable"}, stable, 1'b1);
    check({tag, "_rsp"}, rsp_of(v.n), {v.exp_err, v.exp_res});
    check({tag, "_other_rsp_idle_mul_low"}, {rsp_valid_of(1 - v.n), bus.mul_valid}, 2'b00);
    if (got) ack_rsp(v.n);
    @(negedge clock);
    check({tag, "_back_idle"}, {busy, bus.rsp0_valid, bus.rsp1_valid}, 3'b000);
  endtask

  task automatic agent(input int n, input int nops);
    logic [2:0]  op;
    logic [4:0]  pw;
    logic [31:0] a, b, exp_res;
    logic        exp_err;
    bit          got;
    int          cyc;
    for (int k = 0; k < nops; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      op = 3'(1 << $urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) pw = 5'($urandom_range(0, 31));
      else                           pw = 5'(1 << $urandom_range(0, 4));
      a = $urandom;
      b = $urandom;
      exp_err = !$onehot(pw);
      exp_res = exp_err ? 32'd0 : ref_mul(op, pw, a, b);
      @(negedge clock);
      drive_req(n, 1'b1, op, pw, a, b);
      got = 1'b0;
      for (int c = 0; c < 400; c++) begin
        #1;
        if (req_ready_of(n)) begin
          got = 1'b1;
          break;
        end
        @(negedge clock);
      end
      check($sformatf("rand%0d_accepted", n), got, 1'b1);
      if (!got) begin
        drive_req(n, 1'b0, op, pw, a, b);
        continue;
      end
      @(posedge clock); #1;
      drive_req(n, 1'b0, op, pw, a, b);
      wait_rsp(n, 60, got, cyc);
      check($sformatf("rand%0d_rsp_seen", n), got, 1'b1);
      if (!got) continue;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      check($sformatf("rand%0d_rsp", n), rsp_of(n), {exp_err, exp_res});
      ack_rsp(n);
    end
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[10];

  initial begin
    bit got, ok, held_ok;
    int cyc, mvc;

    vecs[0] = mk(0, 3'b001, 5'b00001, 32'd3,         32'd5,         33, 32'd15,        1'b0, 34, 33);
    vecs[1] = mk(0, 3'b010, 5'b00001, 32'h8000_0000, 32'd4,         33, 32'd2,         1'b0, 34, 33);
    vecs[2] = mk(1, 3'b001, 5'b00010, 32'h0003_0100, 32'h0002_0100, 5,  32'h0006_0000, 1'b0, 6,  5);
    vecs[3] = mk(0, 3'b100, 5'b00100, 32'h0303_0303, 32'h0303_0303, 3,  32'h0505_0505, 1'b0, 4,  3);
    vecs[4] = mk(0, 3'b001, 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'h5555_5555, 1'b0, 2,  1);
    vecs[5] = mk(1, 3'b010, 5'b01000, 32'hFFFF_FFFF, 32'h2222_2222, 2,  32'h1111_1111, 1'b0, 3,  2);
    vecs[6] = mk(0, 3'b001, 5'b00000, 32'd7,         32'd9,         5,  32'd0,         1'b1, 1,  0);
    vecs[7] = mk(1, 3'b001, 5'b00011, 32'd7,         32'd9,         5,  32'd0,         1'b1, 1,  0);
    vecs[8] = mk(0, 3'b001, 5'b00001, 32'd3,         32'd5,         0,  32'd0,         1'b1, 41, 40);
    vecs[9] = mk(0, 3'b001, 5'b00001, 32'd6,         32'd7,         40, 32'd42,        1'b0, 41, 40);

    drive_req(0, 1'b0, 3'b0, 5'b0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 3'b0, 5'b0, 32'd0, 32'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    check_outputs_zero("reset");

    // Contention at reset exit: req0 wins the first tie, then req1 wins the next one.
    stub_lat = 4;
    drive_req(0, 1'b1, 3'b001, 5'b00001, 32'd3, 32'd5);
    drive_req(1, 1'b1, 3'b010, 5'b00010, 32'hFFFF_0100, 32'h0002_0300);
    #1;
    check("cont_no_ready_in_reset", {bus.req0_ready, bus.req1_ready}, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("cont_first_grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
    @(posedge clock); #1;
    drive_req(0, 1'b0, 3'b001, 5'b00001, 32'd3, 32'd5);
    ok = 1'b1; got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock); #1;
      if (bus.req1_ready) ok = 1'b0;
      if (bus.rsp0_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("cont_req1_stalled", ok, 1'b1);
    check("cont_rsp0", {got, rsp_of(0)}, {1'b1, 1'b0, 32'd15});
    ack_rsp(0);
    drive_req(0, 1'b1, 3'b100, 5'b00100, 32'h0303_0303, 32'h0303_0303);
    @(negedge clock); #1;
    check("cont_second_grant", {bus.req0_ready, bus.req1_ready}, 2'b01);
    @(posedge clock); #1;
    drive_req(1, 1'b0, 3'b010, 5'b00010, 32'hFFFF_0100, 32'h0002_0300);
    wait_rsp(1, 60, got, cyc);
    check("cont_rsp1", {got, rsp_of(1)}, {1'b1, 1'b0, 32'h0001_0003});
    if (got) ack_rsp(1);
    @(negedge clock); #1;
    check("cont_third_grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
    @(posedge clock); #1;
    drive_req(0, 1'b0, 3'b100, 5'b00100, 32'h0303_0303, 32'h0303_0303);
    wait_rsp(0, 60, got, cyc);
    check("cont_rsp0_clmul", {got, rsp_of(0)}, {1'b1, 1'b0, 32'h0505_0505});
    if (got) ack_rsp(0);

    // Directed vectors, including illegal widths and the timeout boundary.
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held 10 cycles while another request waits.
    stub_lat = 2;
    @(negedge clock);
    drive_req(0, 1'b1, 3'b001, 5'b00001, 32'd100, 32'd200);
    #1;
    check("bp_accept", bus.req0_ready, 1'b1);
    @(posedge clock); #1;
    drive_req(0, 1'b0, 3'b001, 5'b00001, 32'd100, 32'd200);
    wait_rsp(0, 60, got, cyc);
    check("bp_rsp", {got, rsp_of(0)}, {1'b1, 1'b0, 32'd20000});
    drive_req(1, 1'b1, 3'b001, 5'b00001, 32'd9, 32'd9);
    held_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); #1;
      if (!(bus.rsp0_valid && busy && !bus.req0_ready && !bus.req1_ready &&
            !bus.rsp0_err && bus.rsp0_result == 32'd20000)) held_ok = 1'b0;
    end
    check("bp_held_stable", held_ok, 1'b1);
    ack_rsp(0);
    @(negedge clock); #1;
    check("bp_next_accept", bus.req1_ready, 1'b1);
    @(posedge clock); #1;
    drive_req(1, 1'b0, 3'b001, 5'b00001, 32'd9, 32'd9);
    wait_rsp(1, 60, got, cyc);
    check("bp_rsp1", {got, rsp_of(1)}, {1'b1, 1'b0, 32'd81});
    if (got) ack_rsp(1);

    // Reset in the 10th BUSY cycle, then a normal operation.
    stub_lat = 0;
    @(negedge clock);
    drive_req(0, 1'b1, 3'b001, 5'b00001, 32'hABCD_0001, 32'h1234_5678);
    @(posedge clock); #1;
    drive_req(0, 1'b0, 3'b001, 5'b00001, 32'hABCD_0001, 32'h1234_5678);
    mvc = 0;
    for (int c = 0; c < 30 && mvc < 10; c++) begin
      @(negedge clock);
      if (bus.mul_valid) mvc++;
    end
    check("rstmid_reached_busy10", mvc, 10);
    reset = 1'b1;
    @(negedge clock); #1;
    check_outputs_zero("rstmid");
    reset = 1'b0;
    run_vec(vecs[0], "rstmid_follow");

    // Random traffic from both requesters with random multiplier latency.
    stub_rand = 1'b1;
    fork
      agent(0, 40);
      agent(1, 40);
    join

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/p_mul_sched.md
Name: p_mul_sched

Overview:
- Two-requester scheduler that shares one packed multiplier (packed mul / carry-less mul unit) between two issuing agents, e.g. the core's issue port and a crypto co-processor sequencer.
- Arbitrates round-robin and latches operands so they are held stable for the whole multi-cycle operation.
- Holds the multiplier's valid high until its single-cycle ready pulse, captures the result, and returns it on a per-requester response handshake.
- Screens out illegal pack widths and aborts hung operations via a timeout.

Parameters:
- TIMEOUT, 40, maximum cycles mul_valid may stay high without mul_ready before abort. Must be at least 34; the worst case is pw=32, which needs 33 cycles.
- TMR_W, 6, width of the timeout counter. Must satisfy 2^TMR_W > TIMEOUT.

Ports:
- clock  in  1  single clock; all logic posedge.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  (N=0,1) request present.
- reqN_ready  out  1  request accepted this cycle.
- reqN_op  in  3  {clmul, mul_h, mul_l}.
- reqN_pw  in  5  one-hot pack width: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2.
- reqN_crs1  in  32  multiplicand.
- reqN_crs2  in  32  multiplier.
- rspN_valid  out  1  response available for requester N.
- rspN_ready  in  1  requester N takes response.
- rspN_result  out  32  product (0 on error).
- rspN_err  out  1  1 = illegal pw or timeout.
- mul_valid  out  1  to multiplier valid.
- mul_ready  in  1  from multiplier ready, a 1-cycle finish pulse.
- mul_op  out  3  latched op.
- mul_pw  out  5  latched pw.
- mul_crs1  out  32  latched operand.
- mul_crs2  out  32  latched operand.
- mul_result  in  32  multiplier result, valid while mul_ready=1.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, on reset=1):
  - state=IDLE, rr_last=1 (req0 wins first tie), owner=0, timer=0.
  - Operand, op and result latches cleared to 0.
  - All outputs 0: reqN_ready, rspN_valid, rspN_err, rspN_result, mul_valid, mul_* and busy.
  - Reset wins over every other event.
- States: IDLE, BUSY, RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, the one != rr_last.
  - reqN_ready = (state==IDLE) & grant==N, combinational from reqN_valid. No ready is given to a non-valid requester.
  - On handshake: latch op/pw/crs1/crs2, set owner=N, clear timer.
  - pw legal (exactly one bit set) -> BUSY next cycle.
  - pw illegal (zero or more than one bit set) -> RESP with err=1, result=0; mul_valid is never raised.
- BUSY:
  - mul_valid=1; mul_op/pw/crs1/crs2 driven from the latches, stable for the entire BUSY interval.
  - mul_ready=1 -> latch mul_result, err=0, go to RESP. mul_valid drops the next cycle, so the multiplier's internal counter clears.
  - mul_ready=0 and timer==TIMEOUT-1 -> abort: go to RESP, err=1, result=0. mul_valid has then been high exactly TIMEOUT cycles.
  - Otherwise timer increments.
  - mul_ready in the same cycle as the timeout condition counts as success.
- RESP:
  - rsp[owner]_valid=1 with registered result/err; the other rsp_valid stays 0.
  - Result/err are held stable until rsp[owner]_ready.
  - On handshake: go to IDLE, rr_last=owner.
  - Minimum spacing is one idle cycle between operations, so mul_valid is low for at least 2 cycles between ops.
- Latency, accept to rsp_valid: 1 + k cycles, where k is the cycle count until mul_ready, counting the first BUSY cycle as 1. For a pw=32 legal op the multiplier's k=33, so latency is 34. Illegal pw latency is 1.
- Requests arriving while not IDLE are stalled (ready=0); inputs need not be stable until accepted.
- mul_ready outside BUSY is ignored.
- rspN_ready outside RESP, or for the non-owner, is ignored.
- Dropping reqN_valid before handshake is allowed and has no side effects.

Test Plan:
- Single op: req0, op=mul_l, pw=5'b00001, crs1=3, crs2=5 with the real multiplier.
  - mul_valid high 33 cycles; rsp0_valid on cycle 34 after accept; result=15, err=0.
- Contention: req0 and req1 both valid at reset exit with distinct ops.
  - req0 served first; req1 accepted in the first IDLE after rsp0 handshake.
  - If req0 is re-asserted immediately, req1 still wins that tie (round-robin).
- Illegal pw: req1 pw=5'b00011.
  - rsp1_valid one cycle after accept, err=1, result=0; mul_valid never asserted.
- Timeout: stub multiplier never raises mul_ready, TIMEOUT=40.
  - mul_valid high exactly 40 cycles, then rsp0 err=1, result=0, then mul_valid=0.
  - Variant: mul_ready on the 40th cycle -> err=0, result captured.
- Backpressure: rsp0_ready held 0 for 10 cycles after rsp0_valid.
  - result/err stable; no new request accepted; busy=1 throughout.
- Reset mid-BUSY: assert reset at BUSY cycle 10.
  - Next cycle: all outputs 0, state IDLE; a following request completes normally.
